// File: rtl/key_unlock_ctrl.sv
// Key-unlock controller: loads a serial key, then issues add operations to a locked adder.
// Optional KEY_ZEROIZE_EN drives key_out to 0 except in ARMED/EXEC.
module key_unlock_ctrl #(
  parameter int unsigned KEY_W     = 4,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_LOADS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load_start,
  input  logic              key_bit_valid,
  input  logic              key_bit_in,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W:0]   adder_sum,
  output logic [DATA_W-1:0] adder_a,
  output logic [DATA_W-1:0] adder_b,
  output logic [KEY_W-1:0]  key_out,
  output logic              res_valid,
  output logic [DATA_W:0]   res_sum,
  output logic              locked_out,
  output logic [1:0]        load_count
);

  typedef enum logic [2:0] {StIdle, StShift, StArmed, StExec, StLockout} state_e;

  localparam int unsigned     CNT_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [1:0]      MaxLoads = 2'(MAX_LOADS);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(KEY_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [KEY_W-1:0]    shadow_q, shadow_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [KEY_W-1:0]    key_out_q, key_out_d;
  logic [DATA_W-1:0]   adder_a_q, adder_a_d;
  logic [DATA_W-1:0]   adder_b_q, adder_b_d;
  logic [DATA_W:0]     res_sum_q, res_sum_d;
  logic                res_valid_q, res_valid_d;
  logic [1:0]          load_count_q, load_count_d;
  logic                start_req;
  logic [KEY_W-1:0]    shadow_shifted;

  // A load request is honoured from IDLE, SHIFT (restart) and ARMED only.
  assign start_req      = key_load_start &&
                          (state_q == StIdle || state_q == StShift || state_q == StArmed);
  assign shadow_shifted = KEY_W'({shadow_q, key_bit_in});

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shadow_d     = shadow_q;
    key_d        = key_q;
    adder_a_d    = adder_a_q;
    adder_b_d    = adder_b_q;
    res_sum_d    = res_sum_q;
    res_valid_d  = 1'b0;
    load_count_d = load_count_q;

    if (start_req) begin
      if (load_count_q == MaxLoads) begin
        state_d = StLockout;
      end else begin
        state_d      = StShift;
        bit_cnt_d    = '0;
        shadow_d     = '0;
        load_count_d = load_count_q + 2'd1;
      end
    end else begin
      case (state_q)
        StShift: begin
          if (key_bit_valid) begin
            shadow_d = shadow_shifted;
            if (bit_cnt_q == LastBit) begin
              key_d     = shadow_shifted;
              bit_cnt_d = '0;
              state_d   = StArmed;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StArmed: begin
          if (op_valid) begin
            adder_a_d = a_in;
            adder_b_d = b_in;
            state_d   = StExec;
          end
        end
        StExec: begin
          res_sum_d   = adder_sum;
          res_valid_d = 1'b1;
          state_d     = StArmed;
        end
        default: ;
      endcase
    end
  end

`ifdef KEY_ZEROIZE_EN
  assign key_out_d = (state_d == StArmed || state_d == StExec) ? key_d : '0;
`else
  assign key_out_d = key_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      key_q        <= '0;
      key_out_q    <= '0;
      adder_a_q    <= '0;
      adder_b_q    <= '0;
      res_sum_q    <= '0;
      res_valid_q  <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_q     <= shadow_d;
      key_q        <= key_d;
      key_out_q    <= key_out_d;
      adder_a_q    <= adder_a_d;
      adder_b_q    <= adder_b_d;
      res_sum_q    <= res_sum_d;
      res_valid_q  <= res_valid_d;
      load_count_q <= load_count_d;
    end
  end

  assign op_ready   = (state_q == StArmed) && !key_load_start;
  assign adder_a    = adder_a_q;
  assign adder_b    = adder_b_q;
  assign key_out    = key_out_q;
  assign res_valid  = res_valid_q;
  assign res_sum    = res_sum_q;
  assign locked_out = (state_q == StLockout);
  assign load_count = load_count_q;

endmodule

// File: tb/tb_key_unlock_ctrl.sv
// Self-checking bench for key_unlock_ctrl: behavioural model compared every cycle,
// plus directed literal expectations. Honours KEY_ZEROIZE_EN if defined.
module tb_key_unlock_ctrl;
  localparam int KEY_W     = 4;
  localparam int DATA_W    = 4;
  localparam int MAX_LOADS = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_load_start = 1'b0;
  logic              key_bit_valid = 1'b0;
  logic              key_bit_in = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [DATA_W-1:0] a_in = '0;
  logic [DATA_W-1:0] b_in = '0;
  logic [DATA_W:0]   adder_sum;
  logic [DATA_W-1:0] adder_a;
  logic [DATA_W-1:0] adder_b;
  logic [KEY_W-1:0]  key_out;
  logic              res_valid;
  logic [DATA_W:0]   res_sum;
  logic              locked_out;
  logic [1:0]        load_count;

  key_unlock_ctrl #(.KEY_W(KEY_W), .DATA_W(DATA_W), .MAX_LOADS(MAX_LOADS)) dut (
    .clk(clk), .rst(rst), .key_load_start(key_load_start), .key_bit_valid(key_bit_valid),
    .key_bit_in(key_bit_in), .op_valid(op_valid), .op_ready(op_ready), .a_in(a_in),
    .b_in(b_in), .adder_sum(adder_sum), .adder_a(adder_a), .adder_b(adder_b),
    .key_out(key_out), .res_valid(res_valid), .res_sum(res_sum), .locked_out(locked_out),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Adder stub: plain unlocked sum of the registered operands.
  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes as flags, key bits collected in a queue.
  bit                m_init = 0;
  bit                m_locked, m_loading, m_armed, m_exec, m_rv;
  bit                m_bits[$];
  int                m_loads;
  logic [KEY_W-1:0]  m_key;
  logic [DATA_W-1:0] m_a, m_b;
  logic [DATA_W:0]   m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_locked = 0; m_loading = 0; m_armed = 0; m_exec = 0; m_rv = 0;
      m_bits.delete(); m_loads = 0; m_key = '0; m_a = '0; m_b = '0; m_res = '0;
    end else begin
      m_rv = 0;
      if (m_locked) begin
      end else if (m_exec) begin
        m_res  = {1'b0, m_a} + {1'b0, m_b};
        m_rv   = 1;
        m_exec = 0;
      end else if (key_load_start) begin
        m_armed = 0;
        if (m_loads == MAX_LOADS) begin
          m_locked  = 1;
          m_loading = 0;
        end else begin
          m_loads++;
          m_loading = 1;
          m_bits.delete();
        end
      end else if (m_loading) begin
        if (key_bit_valid) begin
          m_bits.push_back(key_bit_in);
          if (m_bits.size() == KEY_W) begin
            m_key = '0;
            foreach (m_bits[i]) m_key = {m_key[KEY_W-2:0], m_bits[i]};
            m_loading = 0;
            m_armed   = 1;
          end
        end
      end else if (m_armed && op_valid) begin
        m_a = a_in; m_b = b_in; m_exec = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
`ifdef KEY_ZEROIZE_EN
      check("key_out", key_out, m_armed ? m_key : '0);
`else
      check("key_out", key_out, m_key);
`endif
      check("op_ready", op_ready, m_armed && !m_exec && !key_load_start);
      check("adder_a", adder_a, m_a);
      check("adder_b", adder_b, m_b);
      check("res_valid", res_valid, m_rv);
      check("res_sum", res_sum, m_res);
      check("locked_out", locked_out, m_locked);
      check("load_count", load_count, m_loads);
    end
  end

  task automatic cyc(input logic ls, input logic bv, input logic bi, input logic ov,
                     input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    key_load_start = ls; key_bit_valid = bv; key_bit_in = bi;
    op_valid = ov; a_in = a; b_in = b;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic kbit(input logic b);
    cyc(0, 1, b, 0, 0, 0);
  endtask

  task automatic start();
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    idle();
    check("rst key_out", key_out, 0);
    check("rst load_count", load_count, 0);
    check("rst locked_out", locked_out, 0);
    check("rst op_ready", op_ready, 0);
    check("rst res_valid", res_valid, 0);

    // Key 1010, valid every cycle.
    start();
    kbit(1); kbit(0); kbit(1); kbit(0);
    check("key1 key_out", key_out, 4'b1010);
    check("key1 load_count", load_count, 1);
    check("key1 op_ready", op_ready, 1);

    // 3 + 5 through the stub.
    cyc(0, 0, 0, 1, 4'd3, 4'd5);
    check("op adder_a", adder_a, 3);
    check("op adder_b", adder_b, 5);
    check("op exec rv", res_valid, 0);
    idle();
    check("op res_valid", res_valid, 1);
    check("op res_sum", res_sum, 5'b01000);
    idle();
    check("op rv pulse", res_valid, 0);
    check("op res_sum hold", res_sum, 8);

    // Back-to-back requests: every other one is accepted.
    cyc(0, 0, 0, 1, 4'd1, 4'd2);
    cyc(0, 0, 0, 1, 4'd7, 4'd9);
    cyc(0, 0, 0, 1, 4'd15, 4'd15);
    cyc(0, 0, 0, 1, 4'd8, 4'd8);
    check("b2b res_sum", res_sum, 30);
    idle();
    check("b2b adder_a", adder_a, 15);

    // Key 1100 with valid gaps.
    start();
    kbit(1); idle();
`ifdef KEY_ZEROIZE_EN
    check("gap zeroized key_out", key_out, 0);
`else
    check("gap old key_out", key_out, 4'b1010);
`endif
    kbit(1); idle(); kbit(0); kbit(0);
    check("key2 key_out", key_out, 4'b1100);
    check("key2 load_count", load_count, 2);

    // Load start beats op_valid in ARMED.
    cyc(1, 0, 0, 1, 4'd9, 4'd9);
    check("race adder_a", adder_a, 15);
    check("race load_count", load_count, 3);
    check("race locked_out", locked_out, 0);
    kbit(1); kbit(0);
    start();
    check("lock locked_out", locked_out, 1);
    check("lock load_count", load_count, 3);
    cyc(0, 0, 0, 1, 4'd1, 4'd1);
    check("lock op_ready", op_ready, 0);
    check("lock adder_a", adder_a, 15);
    cyc(1, 1, 1, 0, 0, 0);
    check("lock terminal", locked_out, 1);

    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("unlock locked_out", locked_out, 0);
    check("unlock load_count", load_count, 0);
    check("unlock key_out", key_out, 0);

    // Restart mid-shift, final key 0110.
    start();
    kbit(1); kbit(1);
    start();
    kbit(0); kbit(1); kbit(1); kbit(0);
    check("restart key_out", key_out, 4'b0110);
    check("restart load_count", load_count, 2);

    // Reset during EXEC drops the result.
    cyc(0, 0, 0, 1, 4'd15, 4'd15);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("exec rst res_valid", res_valid, 0);
    check("exec rst res_sum", res_sum, 0);
    check("exec rst adder_a", adder_a, 0);
    check("exec rst adder_b", adder_b, 0);
    check("exec rst key_out", key_out, 0);
    idle();
    check("exec rst no pulse", res_valid, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
